pipe_scroller: RTL

- Generates and animates the four pipe obstacles for the flappy-bird game.
- Feeds the game-state block directly: pipeX, pipeWidth, pipeGapSize and pipeGapLocation, packed [3:0][12:0].
- Consumes gameOn and ded from the game-state block, plus the frame tick from the VGA controller.
- Scrolls pipes left once per frame and recycles each pipe to the right with a pseudo-random gap height.

---
 rtl/pipe_scroller.sv | 109 ++++++++++
 1 files changed

// File: rtl/pipe_scroller.sv
// Four-pipe obstacle generator for the flappy-bird game: scrolls pipes left one
// pixel per frame and recycles each pipe to the right with an LFSR-derived gap height.
module pipe_scroller #(
  parameter int          SCREEN_W     = 640,
  parameter int          PIPE_SPACING = 160,
  parameter int          PIPE_HALF_W  = 20,
  parameter int          GAP_HALF     = 60,
  parameter int          SPEED        = 1,
  parameter int          GAP_MIN      = 100,
  parameter int          GAP_MAX      = 380,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             frame_clk,
  input  logic             gameOn,
  input  logic             ded,
  output logic [3:0][12:0] pipeX,
  output logic [3:0][12:0] pipeWidth,
  output logic [3:0][12:0] pipeGapSize,
  output logic [3:0][12:0] pipeGapLocation,
  output logic             scrolling
);

  localparam logic [12:0] SPEED_W   = 13'(SPEED);
  localparam logic [12:0] RANGE_W   = 13'(GAP_MAX - GAP_MIN);
  localparam logic [12:0] WRAP_STEP = 13'(4 * PIPE_SPACING - SPEED);
  localparam logic [12:0] GAP_MIN_W = 13'(GAP_MIN);
  localparam logic [12:0] GAP_MID_W = 13'((GAP_MIN + GAP_MAX) / 2);
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             frame_d;
  logic             tick;
  logic [15:0]      lfsr, lfsr_nxt;
  logic [3:0][12:0] pipe_x_nxt, gap_loc_nxt;
  logic [12:0]      r9, gap_new;

  assign tick     = frame_clk & ~frame_d;
  assign lfsr_nxt = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);

  // Fold the 9-bit random value into [0, RANGE]; one subtraction suffices since RANGE >= 256.
  assign r9      = {4'd0, lfsr[8:0]};
  assign gap_new = GAP_MIN_W + ((r9 <= RANGE_W) ? r9 : (r9 - RANGE_W - 13'd1));

  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_nxt   = state;
    pipe_x_nxt  = pipeX;
    gap_loc_nxt = pipeGapLocation;
    unique case (state)
      IDLE: begin
        if (ded)         state_nxt = FROZEN;
        else if (gameOn) state_nxt = RUN;
      end
      RUN: begin
        if (ded)          state_nxt = FROZEN;
        else if (!gameOn) state_nxt = IDLE;
        // The update still lands on the cycle ded arrives, since state is RUN here.
        if (tick) begin
          for (int i = 0; i < 4; i++) begin
            if (pipeX[i] >= SPEED_W) begin
              pipe_x_nxt[i] = pipeX[i] - SPEED_W;
            end else begin
              pipe_x_nxt[i]  = pipeX[i] + WRAP_STEP;
              gap_loc_nxt[i] = gap_new;
            end
          end
        end
      end
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      frame_d   <= 1'b0;
      lfsr      <= LFSR_SEED;
      scrolling <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        pipeX[i]           <= 13'(SCREEN_W + PIPE_HALF_W + i * PIPE_SPACING);
        pipeGapLocation[i] <= GAP_MID_W;
      end
    end else begin
      state           <= state_nxt;
      frame_d         <= frame_clk;
      lfsr            <= lfsr_nxt;
      scrolling       <= (state_nxt == RUN);
      pipeX           <= pipe_x_nxt;
      pipeGapLocation <= gap_loc_nxt;
    end
  end

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      pipeWidth[i]   = 13'(PIPE_HALF_W);
      pipeGapSize[i] = 13'(GAP_HALF);
    end
  end

endmodule
